// File: rtl/accum_table_rmw.sv
// Per-column banked accumulator table: overwrite or read-modify-write accumulate,
// post-reset zero sweep, S2 hazard forwarding. Define ACCUM_SAT_EN for saturating accumulate.
module accum_table_rmw #(
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_ROWS_NUM = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_COLS = 16,
    localparam int NUM_ACCUM_ROWS = MAX_ROWS_NUM * (MAX_OUT_COLS / SYS_ARR_COLS),
    localparam int ADDR_W = $clog2(NUM_ACCUM_ROWS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic                                 init_busy,
    input  logic [SYS_ARR_COLS-1:0]              wr_en,
    input  logic [SYS_ARR_COLS-1:0]              wr_mode,
    input  logic [ADDR_W*SYS_ARR_COLS-1:0]       wr_address,
    input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0]   wr_data,
    input  logic [SYS_ARR_COLS-1:0]              rd_en,
    input  logic [ADDR_W*SYS_ARR_COLS-1:0]       rd_address,
    output logic [DATA_WIDTH*SYS_ARR_COLS-1:0]   rd_data,
    output logic [SYS_ARR_COLS-1:0]              rd_valid
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ACCUM_ROWS - 1);
    localparam logic [ADDR_W:0]   ROW_LIMIT = (ADDR_W + 1)'(NUM_ACCUM_ROWS);
`ifdef ACCUM_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        sweep_cnt_q, sweep_cnt_d;
    logic                     init_busy_q, init_busy_d;

    logic [DATA_WIDTH-1:0]    mem [SYS_ARR_COLS][NUM_ACCUM_ROWS];

    logic [SYS_ARR_COLS-1:0]                   s2_vld_q, s2_vld_d;
    logic [SYS_ARR_COLS-1:0]                   s2_mode_q, s2_mode_d;
    logic [SYS_ARR_COLS-1:0][ADDR_W-1:0]       s2_addr_q, s2_addr_d;
    logic [SYS_ARR_COLS-1:0][DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic [SYS_ARR_COLS-1:0][DATA_WIDTH-1:0]   s2_old_q, s2_old_d;
    logic [SYS_ARR_COLS-1:0][DATA_WIDTH-1:0]   s2_res;
    logic [SYS_ARR_COLS-1:0][DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [SYS_ARR_COLS-1:0]                   rd_valid_q, rd_valid_d;
    logic [SYS_ARR_COLS-1:0][ADDR_W-1:0]       rd_addr;

    assign rd_addr   = rd_address;
    assign init_busy = init_busy_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < ROW_LIMIT;
    endfunction

    always_comb begin
`ifdef ACCUM_SAT_EN
        logic [DATA_WIDTH:0] sum;
        sum = '0;
`endif
        s2_res = '0;
        for (int c = 0; c < SYS_ARR_COLS; c++) begin
            if (!s2_mode_q[c]) begin
                s2_res[c] = s2_data_q[c];
            end else begin
`ifdef ACCUM_SAT_EN
                sum = {s2_old_q[c][DATA_WIDTH-1], s2_old_q[c]}
                    + {s2_data_q[c][DATA_WIDTH-1], s2_data_q[c]};
                if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
                    s2_res[c] = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
                else
                    s2_res[c] = sum[DATA_WIDTH-1:0];
`else
                s2_res[c] = s2_old_q[c] + s2_data_q[c];
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        init_busy_d = init_busy_q;
        s2_vld_d    = '0;
        s2_mode_d   = wr_mode;
        s2_addr_d   = wr_address;
        s2_data_d   = wr_data;
        s2_old_d    = s2_old_q;
        rd_valid_d  = '0;
        rd_data_d   = rd_data_q;
        if (state_q == INIT) begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
            if (sweep_cnt_q == LAST_ROW) begin
                state_d     = RUN;
                init_busy_d = 1'b0;
            end
        end else begin
            for (int c = 0; c < SYS_ARR_COLS; c++) begin
                s2_vld_d[c] = wr_en[c] && in_range(s2_addr_d[c]);
                // The S2 write lands in the bank only at the end of this cycle, so forward it.
                if (s2_vld_q[c] && s2_addr_q[c] == s2_addr_d[c])
                    s2_old_d[c] = s2_res[c];
                else if (in_range(s2_addr_d[c]))
                    s2_old_d[c] = mem[c][s2_addr_d[c]];
                else
                    s2_old_d[c] = '0;
                if (rd_en[c]) begin
                    rd_valid_d[c] = 1'b1;
                    if (!in_range(rd_addr[c]))
                        rd_data_d[c] = '0;
                    else if (s2_vld_q[c] && s2_addr_q[c] == rd_addr[c])
                        rd_data_d[c] = s2_res[c];
                    else
                        rd_data_d[c] = mem[c][rd_addr[c]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            sweep_cnt_q <= '0;
            init_busy_q <= 1'b1;
            s2_vld_q    <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            init_busy_q <= init_busy_d;
            s2_vld_q    <= s2_vld_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        s2_mode_q <= s2_mode_d;
        s2_addr_q <= s2_addr_d;
        s2_data_q <= s2_data_d;
        s2_old_q  <= s2_old_d;
    end

    // Bank writes are suppressed during reset so an in-flight S2 result is discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < SYS_ARR_COLS; c++) begin
                if (state_q == INIT)
                    mem[c][sweep_cnt_q] <= '0;
                else if (s2_vld_q[c])
                    mem[c][s2_addr_q[c]] <= s2_res[c];
            end
        end
    end

endmodule
